// File: rtl/cpu_pkg.sv
// Shared CPU constants, fetch-state encoding and the IF/ID payload type.
package cpu_pkg;

  localparam logic [31:0] RESET_PC = 32'h0040_0000;
  localparam int unsigned IMEM_AW  = 11;

  localparam logic [1:0] FS_BOOT  = 2'd0;
  localparam logic [1:0] FS_RUN   = 2'd1;
  localparam logic [1:0] FS_FAULT = 2'd2;

  typedef enum logic [1:0] {
    ST_BOOT  = FS_BOOT,
    ST_RUN   = FS_RUN,
    ST_FAULT = FS_FAULT
  } fetch_state_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

endpackage

// File: rtl/ifetch_addr_map.sv
// Byte address to memory word address, with misalignment and out-of-range detection.
module ifetch_addr_map #(
  parameter logic [31:0] BASE = 32'h0000_0000,
  parameter int unsigned AW   = 11
) (
  input  logic [31:0]   addr,
  output logic [AW-1:0] word_addr_c,
  output logic          bad_c
);

  logic [31:0] off;

  always_comb begin
    off         = addr - BASE;
    word_addr_c = off[AW+1:2];
    bad_c       = (off[1:0] != 2'b00) || (off[31:AW+2] != '0);
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch front end: PC, ROM addressing, IF/ID register, fault capture.
module ifetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC,
  parameter int unsigned IMEM_AW  = cpu_pkg::IMEM_AW
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_instr,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic [31:0]        pc,
  output logic [31:0]        if_id_instr,
  output logic [31:0]        if_id_pc,
  output logic               if_id_valid,
  output logic               fetch_fault,
  output logic [31:0]        fault_pc,
  output logic [31:0]        fetch_count
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  if_id_t       if_id_q, if_id_d;
  logic         fault_q, fault_d;
  logic [31:0]  fault_pc_q, fault_pc_d;
  logic [31:0]  count_q, count_d;
  logic         bad;

  ifetch_addr_map #(
    .BASE (RESET_PC),
    .AW   (IMEM_AW)
  ) u_addr_map (
    .addr        (pc_q),
    .word_addr_c (imem_addr),
    .bad_c       (bad)
  );

  // Next-state and next-register values; redirect outranks stall, stall outranks fault.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_id_d    = if_id_q;
    fault_d    = fault_q;
    fault_pc_d = fault_pc_q;
    count_d    = count_q;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (redirect_valid) begin
          pc_d          = redirect_pc;
          if_id_d.valid = 1'b0;
        end else if (stall) begin
          pc_d = pc_q;
        end else if (bad) begin
          fault_d       = 1'b1;
          fault_pc_d    = pc_q;
          if_id_d.valid = 1'b0;
          state_d       = ST_FAULT;
        end else begin
          if_id_d.instr = imem_instr;
          if_id_d.pc    = pc_q;
          if_id_d.valid = 1'b1;
          pc_d          = pc_q + 32'd4;
          count_d       = count_q + 32'd1;
        end
      end
      ST_FAULT: begin
        fault_d       = 1'b1;
        if_id_d.valid = 1'b0;
      end
      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      if_id_q    <= '0;
      fault_q    <= 1'b0;
      fault_pc_q <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_id_q    <= if_id_d;
      fault_q    <= fault_d;
      fault_pc_q <= fault_pc_d;
      count_q    <= count_d;
    end
  end

  assign pc          = pc_q;
  assign if_id_instr = if_id_q.instr;
  assign if_id_pc    = if_id_q.pc;
  assign if_id_valid = if_id_q.valid;
  assign fetch_fault = fault_q;
  assign fault_pc    = fault_pc_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: ROM model, reference model and delivery scoreboard.
module tb_ifetch_unit;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] imem_addr;
  logic [31:0] imem_instr;
  logic        stall, redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] pc, if_id_instr, if_id_pc, fault_pc, fetch_count;
  logic        if_id_valid, fetch_fault;

  logic [31:0] rom [2048];
  assign imem_instr = rom[imem_addr];

  ifetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .pc             (pc),
    .if_id_instr    (if_id_instr),
    .if_id_pc       (if_id_pc),
    .if_id_valid    (if_id_valid),
    .fetch_fault    (fetch_fault),
    .fault_pc       (fault_pc),
    .fetch_count    (fetch_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model
  int          m_state;
  logic [31:0] m_pc, m_fpc, m_cnt, m_ifpc, m_ifinstr;
  logic        m_valid, m_fault;
  sb_t         sb_q[$];

  function automatic logic m_bad(input logic [31:0] a);
    logic [31:0] off;
    off = a - RST_PC;
    return (off % 4 != 0) || (off >= 32'h0000_2000);
  endfunction

  function automatic logic [31:0] rom_at(input logic [31:0] a);
    logic [31:0] off;
    off = (a - RST_PC) >> 2;
    return rom[off[10:0]];
  endfunction

  task automatic model_reset();
    m_state = 0; m_pc = RST_PC; m_fpc = 0; m_cnt = 0;
    m_ifpc = 0; m_ifinstr = 0; m_valid = 0; m_fault = 0;
    sb_q.delete();
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"}, pc, m_pc);
    check({tag, ".valid"}, 32'(if_id_valid), 32'(m_valid));
    check({tag, ".fault"}, 32'(fetch_fault), 32'(m_fault));
    check({tag, ".fault_pc"}, fault_pc, m_fpc);
    check({tag, ".count"}, fetch_count, m_cnt);
    check({tag, ".if_pc"}, if_id_pc, m_ifpc);
    check({tag, ".if_instr"}, if_id_instr, m_ifinstr);
  endtask

  // One clock cycle: drive inputs, advance model, compare after the edge.
  task automatic step(input string tag, input logic s, input logic r, input logic [31:0] rp);
    logic deliver;
    sb_t  e;
    deliver = 1'b0;
    stall = s; redirect_valid = r; redirect_pc = rp;
    case (m_state)
      0: m_state = 1;
      1: begin
        if (r) begin
          m_pc = rp; m_valid = 0;
        end else if (!s) begin
          if (m_bad(m_pc)) begin
            m_fault = 1; m_fpc = m_pc; m_valid = 0; m_state = 2;
          end else begin
            sb_q.push_back('{pc: m_pc, instr: rom_at(m_pc)});
            m_ifpc = m_pc; m_ifinstr = rom_at(m_pc);
            m_pc = m_pc + 4; m_valid = 1; m_cnt = m_cnt + 1;
            deliver = 1'b1;
          end
        end
      end
      default: m_valid = 0;
    endcase
    @(posedge clk); #1;
    check_all(tag);
    if (deliver) begin
      e = sb_q.pop_front();
      check({tag, ".sb_pc"}, if_id_pc, e.pc);
      check({tag, ".sb_instr"}, if_id_instr, e.instr);
    end
  endtask

  task automatic release_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    step("boot", 1'b0, 1'b0, 32'h0);
    check("boot_state_valid", 32'(if_id_valid), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2048; i++) rom[i] = 32'hA500_0000 | 32'(i);
    rom[0] = 32'h2001_0001; rom[1] = 32'h2002_0002;
    rom[2] = 32'h2003_0003; rom[3] = 32'h0000_0000;
    rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_all("reset");
    release_reset();

    // Sequential fetch, stall at 0x00400008, resume
    step("seq0", 1'b0, 1'b0, 32'h0);
    check("seq0_pc_abs", if_id_pc, 32'h0040_0000);
    step("seq1", 1'b0, 1'b0, 32'h0);
    step("stall0", 1'b1, 1'b0, 32'h0);
    step("stall1", 1'b1, 1'b0, 32'h0);
    check("stall_pc_abs", pc, 32'h0040_0008);
    step("seq2", 1'b0, 1'b0, 32'h0);
    check("seq2_instr_abs", if_id_instr, 32'h2003_0003);
    check("count3_abs", fetch_count, 32'd3);
    step("seq3", 1'b0, 1'b0, 32'h0);

    // Redirect together with stall: one bubble then target
    step("redir", 1'b1, 1'b1, 32'h0040_0040);
    check("redir_pc_abs", pc, 32'h0040_0040);
    step("redir_tgt", 1'b0, 1'b0, 32'h0);
    check("redir_instr_abs", if_id_instr, 32'hA500_0010);
    step("redir_next", 1'b0, 1'b0, 32'h0);

    // Redirect to a misaligned target, then fault is terminal
    step("mis_redir", 1'b0, 1'b1, 32'h0040_0042);
    step("mis_fault", 1'b0, 1'b0, 32'h0);
    check("mis_fpc_abs", fault_pc, 32'h0040_0042);
    step("flt_redir", 1'b0, 1'b1, 32'h0040_0100);
    step("flt_stall", 1'b1, 1'b1, 32'h0040_0200);
    step("flt_idle", 1'b0, 1'b0, 32'h0);

    // Asynchronous reset away from any clock edge
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all("async_rst");
    release_reset();
    step("rerun0", 1'b0, 1'b0, 32'h0);
    check("rerun_pc_abs", if_id_pc, 32'h0040_0000);
    step("rerun1", 1'b0, 1'b0, 32'h0);

    // End of ROM: last word delivered, next PC faults
    step("eor_redir", 1'b0, 1'b1, 32'h0040_1FFC);
    step("eor_last", 1'b0, 1'b0, 32'h0);
    check("eor_instr_abs", if_id_instr, 32'hA500_07FF);
    step("eor_fault", 1'b0, 1'b0, 32'h0);
    check("eor_fpc_abs", fault_pc, 32'h0040_2000);
    step("eor_hold", 1'b0, 1'b1, 32'h0040_0000);

    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all("async_rst2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
